// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch unit with redirect
//
// Fetches one instruction word at a time from instruction memory over a
// req/gnt + rvalid handshake, holds it for the control unit until consumed,
// then fetches either the sequential successor or a redirect target.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bits [1:0] != 0 raises the sticky
//               misalign_err flag and parks the unit in HALT until reset.
//   undefined : target bits [1:0] are dropped and misalign_err is tied low.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and byte address to memory
//   imem_gnt              memory accepted the request this cycle
//   imem_rvalid/rdata     fetched word returned by memory
//   IMEMout               registered instruction word to the control unit
//   instr_valid           IMEMout/pc_out hold a live instruction
//   instr_ready           downstream consumes the instruction this cycle
//   PCSel/alu_result      redirect select and target, sampled on consume
//   pc_out/pc_plus4       address of IMEMout and its +4 link value
//   instr_count           number of consumed instructions (wraps)
//   misalign_err          sticky redirect misalignment flag
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IMEMout,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSel,
    input  logic [31:0] alu_result,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count,
    output logic        misalign_err
);

    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [2:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        take_trap;

    // Redirect targets are always word aligned; the low bits only matter
    // for the optional trap.
    assign next_pc = PCSel ? {alu_result[31:2], 2'b00} : pc_out + 32'd4;

`ifdef IFU_MISALIGN_TRAP_EN
    logic trap_q;

    assign take_trap    = PCSel & (|alu_result[1:0]);
    assign misalign_err = trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (state == ST_HOLD && instr_ready && take_trap) begin
            trap_q <= 1'b1;
        end
    end
`else
    logic unused_low_bits;

    assign take_trap       = 1'b0;
    assign misalign_err    = 1'b0;
    assign unused_low_bits = &{1'b0, alu_result[1:0]};
`endif

    // The request is a pure function of state so reset drops it at once.
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = imem_req ? fetch_pc : 32'h0000_0000;
    assign pc_plus4  = pc_out + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RST;
            fetch_pc    <= RESET_PC;
            IMEMout     <= NOP_INSTR;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            instr_count <= 32'h0000_0000;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    // An rvalid seen here (even together with gnt) belongs to
                    // some earlier, abandoned fetch and is dropped.
                    if (imem_gnt) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        IMEMout     <= imem_rdata;
                        pc_out      <= fetch_pc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        if (take_trap) begin
                            state <= ST_HALT;
                        end else begin
                            fetch_pc <= next_pc;
                            state    <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch byte address, valid while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 IMEMout  output  32  registered instruction word driven to the control unit.
REQ-010 instr_valid  output  1  IMEMout and pc_out hold a live instruction.
REQ-011 instr_ready  input  1  downstream consumes the instruction this cycle.
REQ-012 PCSel  input  1  take redirect on consume (branch taken, JAL, JALR).
REQ-013 alu_result  input  32  redirect target address.
REQ-014 pc_out  output  32  address of the instruction in IMEMout.
REQ-015 pc_plus4  output  32  pc_out+4, modulo 2^32 (link value for WBSel=2).
REQ-016 instr_count  output  32  number of consumed instructions.
REQ-017 misalign_err  output  1  sticky redirect misalignment flag (see Configuration).

Function
REQ-018 FSM states SHALL be RST, REQ, WAIT, HOLD, HALT.
REQ-019 RST: imem_req=0; SHALL move to REQ on the first clock after rst_n deasserts.
REQ-020 REQ: imem_req=1, imem_addr=fetch_pc; on imem_gnt=1 -> WAIT, else stay with request and address held stable.
REQ-021 WAIT: imem_req=0; on imem_rvalid=1 SHALL capture imem_rdata into IMEMout, fetch_pc into pc_out, set instr_valid=1 -> HOLD.
REQ-022 imem_rvalid outside WAIT SHALL be ignored; a gnt and rvalid in the same cycle SHALL be treated as gnt only.
REQ-023 HOLD: instr_valid=1, IMEMout/pc_out stable until instr_ready=1.
REQ-024 HOLD with instr_ready=1: instr_valid->0, instr_count+1, -> REQ; next fetch_pc = PCSel ? {alu_result[31:2],2'b00} : pc_out+4.
REQ-025 PCSel SHALL be sampled only in the HOLD cycle where instr_ready=1; ignored otherwise.
REQ-026 fetch_pc+4 and instr_count SHALL wrap modulo 2^32 without flag.
REQ-027 Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory.
REQ-028 pc_plus4 SHALL be combinational from pc_out.

Reset
REQ-029 rst_n low SHALL immediately force state RST, imem_req=0, imem_addr=0, IMEMout=32'h0000_0013 (NOP), instr_valid=0, pc_out=RESET_PC, fetch_pc=RESET_PC, instr_count=0, misalign_err=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding fetch; a response arriving after reset release SHALL be discarded.

Configuration
REQ-031 Macro IFU_MISALIGN_TRAP_EN: when defined, a redirect with alu_result[1:0]!=0 SHALL set misalign_err=1 and enter HALT (imem_req=0, instr_valid=0) until reset; when undefined, bits [1:0] SHALL be forced to 0 and misalign_err tied to 0.

Verification
REQ-032 Reset release, RESET_PC=0, zero-wait memory returning 32'h00500093 -> imem_addr=0 in cycle 1, IMEMout=32'h00500093 with instr_valid=1 in cycle 3.
REQ-033 Sequential fetch, instr_ready=1 permanently, 4 instructions -> addresses 0,4,8,C; instr_count=4; pc_plus4=32'h10 on last.
REQ-034 HOLD at pc 32'h20, PCSel=1, alu_result=32'h100 -> next imem_addr=32'h100; instr_ready=0 for 5 cycles holds IMEMout stable.
REQ-035 imem_gnt delayed 3 cycles, rst_n pulsed low in WAIT -> imem_req=0 immediately, later stale rvalid ignored, fetch restarts at RESET_PC.
REQ-036 alu_result=32'h102 redirect -> with IFU_MISALIGN_TRAP_EN: misalign_err=1, HALT, no further requests; without: next imem_addr=32'h100.
